// File: rtl/modbus_frame_tx_pkg.sv
// Shared constants, types and helpers for the Modbus RTU frame transmitter.
//   CRC_INIT / CRC_POLY : Modbus CRC16 start value and reflected polynomial
//   T35_US / FAST_BAUD  : fixed inter-frame silence used above FAST_BAUD
//   state_t             : frame sequencer states
//   phase_t             : which part of the frame is currently on the line
//   gap_cycles()        : t3.5 silence length in clock cycles
//   crc_bit_step()      : one LSB-first step of the reflected CRC
package modbus_frame_tx_pkg;

  localparam logic [15:0] CRC_INIT  = 16'hFFFF;
  localparam logic [15:0] CRC_POLY  = 16'hA001;
  localparam int          T35_US    = 1750;
  localparam int          FAST_BAUD = 19200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_RDWAIT,
    ST_ARM,
    ST_SEND,
    ST_WAITD,
    ST_GAP,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_PAYLOAD,
    PH_CRCLO,
    PH_CRCHI
  } phase_t;

  // Above FAST_BAUD the silence is a fixed 1.75 ms; below it is 3.5 characters
  // of 11 bits (38.5 bit times). 64-bit math keeps CLK_FREQ*385 from overflowing.
  function automatic int gap_cycles(input int clk_freq, input int baud_rate);
    if (baud_rate > FAST_BAUD) return clk_freq / 1000000 * T35_US;
    return int'((longint'(clk_freq) * 385) / (longint'(baud_rate) * 10));
  endfunction

  function automatic logic [15:0] crc_bit_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[0] ^ din;
    return {1'b0, crc[15:1]} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/modbus_frame_tx_if.sv
// Handshake bundle of the frame transmitter.
//   frame_start/frame_len           : frame request from the protocol engine
//   buf_rd_en/buf_rd_addr/buf_rd_data : response buffer read port (1-cycle latency)
//   tx_start/tx_data/tx_done/tx_state : byte interface to uart_byte_tx
//   busy/frame_done/crc_out         : status back to the protocol engine
// Modport master is the frame transmitter, slave is its environment.
interface modbus_frame_tx_if #(
  parameter int ADDR_W = 8
);
  logic              frame_start;
  logic [ADDR_W-1:0] frame_len;
  logic              buf_rd_en;
  logic [ADDR_W-1:0] buf_rd_addr;
  logic [7:0]        buf_rd_data;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_done;
  logic              tx_state;
  logic              busy;
  logic              frame_done;
  logic [15:0]       crc_out;

  modport master (
    input  frame_start, frame_len, buf_rd_data, tx_done, tx_state,
    output buf_rd_en, buf_rd_addr, tx_start, tx_data, busy, frame_done, crc_out
  );

  modport slave (
    output frame_start, frame_len, buf_rd_data, tx_done, tx_state,
    input  buf_rd_en, buf_rd_addr, tx_start, tx_data, busy, frame_done, crc_out
  );
endinterface

// File: rtl/modbus_frame_tx_crc16.sv
// Bit-serial Modbus CRC16 (reflected 0xA001, LSB first).
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : restart the CRC at 0xFFFF
//   start      : begin folding byte_in (8 cycles)
//   crc        : running CRC value
//   ready      : no fold in progress
// Shared with the receive-side checker.
module crc16_modbus_serial
  import modbus_frame_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        start,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc,
  output logic        ready
);

  logic [15:0] crc_q;
  logic [7:0]  shift_q;
  logic [3:0]  bits_left_q;

  // NOTE: registers take non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q       <= CRC_INIT;
      shift_q     <= '0;
      bits_left_q <= '0;
    end else if (load) begin
      crc_q       <= CRC_INIT;
      bits_left_q <= '0;
    end else if (start) begin
      shift_q     <= byte_in;
      bits_left_q <= 4'd8;
    end else if (bits_left_q != 4'd0) begin
      crc_q       <= crc_bit_step(crc_q, shift_q[0]);
      shift_q     <= {1'b0, shift_q[7:1]};
      bits_left_q <= bits_left_q - 4'd1;
    end
  end

  assign crc   = crc_q;
  assign ready = (bits_left_q == 4'd0);

endmodule

// File: rtl/modbus_frame_tx.sv
// Modbus RTU frame transmit sequencer, upstream of uart_byte_tx.
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   bus (master)     : frame request, buffer read port, uart byte handshake,
//                      busy/frame_done/crc_out status
// Reads the payload byte by byte, sends it, appends the CRC low byte then high
// byte, waits the t3.5 silence and pulses frame_done.
module modbus_frame_tx
  import modbus_frame_tx_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int ADDR_W    = 8
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  modbus_frame_tx_if.master  bus
);

  localparam int GAP_CYC = gap_cycles(CLK_FREQ, BAUD_RATE);
  localparam int GAP_W   = $clog2(GAP_CYC + 1);

  state_t            state_q, state_d;
  phase_t            phase_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        tx_data_q;
  logic [15:0]       crc_out_q;
  logic              send_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic [15:0]       crc_val;
  logic              crc_ready;

  logic accept, last_byte, gap_end;

  assign accept    = (state_q == ST_IDLE) && bus.frame_start && (bus.frame_len != '0);
  assign last_byte = (addr_q == len_q - ADDR_W'(1));
  // Counter is loaded with 1 on the final tx_done, so DONE lands GAP_CYC
  // cycles after the cycle that carried tx_done.
  assign gap_end   = (gap_cnt_q == GAP_W'(GAP_CYC - 1));

  crc16_modbus_serial u_crc (
    .clk     (clk_in),
    .rst_n   (rst_n_in),
    .load    (accept),
    .start   (state_q == ST_RDWAIT),
    .byte_in (bus.buf_rd_data),
    .crc     (crc_val),
    .ready   (crc_ready)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_RDWAIT;
      ST_RDWAIT: state_d = ST_ARM;
      ST_ARM:    if (!bus.tx_state) state_d = ST_SEND;
      ST_SEND:   if (send_cnt_q) state_d = ST_WAITD;
      ST_WAITD: begin
        if (bus.tx_done) begin
          if (phase_q == PH_CRCHI)                      state_d = ST_GAP;
          else if (phase_q == PH_PAYLOAD && !last_byte) state_d = ST_FETCH;
          else                                          state_d = ST_ARM;
        end
      end
      ST_GAP:    if (gap_end) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      len_q      <= '0;
      addr_q     <= '0;
      phase_q    <= PH_PAYLOAD;
      tx_data_q  <= '0;
      crc_out_q  <= '0;
      send_cnt_q <= 1'b0;
      gap_cnt_q  <= '0;
    end else begin
      // Toggles 0 -> 1 -> 0 across the two SEND cycles.
      send_cnt_q <= (state_q == ST_SEND) && !send_cnt_q;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            len_q   <= bus.frame_len;
            addr_q  <= '0;
            phase_q <= PH_PAYLOAD;
          end
        end
        ST_RDWAIT: tx_data_q <= bus.buf_rd_data;
        ST_WAITD: begin
          if (bus.tx_done) begin
            case (phase_q)
              PH_PAYLOAD: begin
                if (last_byte) begin
                  tx_data_q <= crc_val[7:0];
                  phase_q   <= PH_CRCLO;
                end else begin
                  addr_q <= addr_q + ADDR_W'(1);
                end
              end
              PH_CRCLO: begin
                tx_data_q <= crc_val[15:8];
                phase_q   <= PH_CRCHI;
              end
              PH_CRCHI: begin
                crc_out_q <= crc_val;
                gap_cnt_q <= GAP_W'(1);
              end
              default: ;
            endcase
          end
        end
        ST_GAP:  gap_cnt_q <= gap_cnt_q + GAP_W'(1);
        default: ;
      endcase
    end
  end

  // tx_start is a pure state decode so an asynchronous reset drops it at once.
  assign bus.buf_rd_en   = (state_q == ST_FETCH);
  assign bus.buf_rd_addr = addr_q;
  assign bus.tx_start    = (state_q == ST_SEND);
  assign bus.tx_data     = tx_data_q;
  assign bus.busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.frame_done  = (state_q == ST_DONE);
  assign bus.crc_out     = crc_out_q;

  // A byte transmission lasts far longer than the 8-cycle fold, so the CRC
  // must be settled by the time any byte completes.
  a_crc_settled: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    (state_q == ST_WAITD && bus.tx_done) |-> crc_ready);

endmodule

// File: tb/tb_modbus_frame_tx.sv
// Self-checking bench for modbus_frame_tx: behavioural uart and buffer models,
// a byte-wise CRC reference and randomized frames.
module tb_modbus_frame_tx;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD_RATE = 115_200;
  localparam int ADDR_W    = 8;
  // Above 19200 baud the silence is 1750 us, i.e. 1750 clocks at 1 MHz.
  localparam int GAP_CYC   = 1750;

  logic clk      = 1'b0;
  logic rst_n_in = 1'b0;
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  logic [7:0] mem [256];
  logic [7:0] line_q [$];
  logic [7:0] cap;
  int         ucnt, hold, start_len, last_done_cyc, first_start_cyc;
  logic       prev_start;
  bit         spurious_en;

  modbus_frame_tx_if #(.ADDR_W(ADDR_W)) bus ();

  modbus_frame_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.buf_rd_en) bus.buf_rd_data <= mem[bus.buf_rd_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_model(input int len);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < len; i++) begin
      c = c ^ {8'h00, mem[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  task automatic outputs_zero(input string tag);
    check({tag, "_tx_start"},   bus.tx_start, 0);
    check({tag, "_buf_rd_en"},  bus.buf_rd_en, 0);
    check({tag, "_buf_rd_addr"}, bus.buf_rd_addr, 0);
    check({tag, "_busy"},       bus.busy, 0);
    check({tag, "_frame_done"}, bus.frame_done, 0);
    check({tag, "_tx_data"},    bus.tx_data, 0);
    check({tag, "_crc_out"},    bus.crc_out, 0);
  endtask

  // uart_byte_tx model: busy for 12..30 cycles per byte, tx_state lingers
  // 0..3 cycles after tx_done, and optional stray tx_done pulses are thrown
  // in whenever the sequencer cannot be waiting for a byte.
  initial begin : uart_model
    bus.tx_done  = 1'b0;
    bus.tx_state = 1'b0;
    ucnt = 0; hold = 0; start_len = 0; prev_start = 1'b0; cap = '0;
    last_done_cyc = 0; first_start_cyc = -1;
    forever begin
      @(negedge clk);
      bus.tx_done = 1'b0;
      if (!rst_n_in) begin
        ucnt = 0; hold = 0; start_len = 0; prev_start = 1'b0;
        bus.tx_state = 1'b0;
      end else begin
        if (ucnt > 0) begin
          ucnt--;
          if (ucnt == 0) begin
            bus.tx_done   = 1'b1;
            last_done_cyc = cyc;
            check("tx_data_held", bus.tx_data, cap);
            hold = $urandom_range(0, 3);
            if (hold == 0) bus.tx_state = 1'b0;
          end
        end else if (hold > 0) begin
          hold--;
          if (hold == 0) bus.tx_state = 1'b0;
          else if (spurious_en && $urandom_range(0, 1) == 1) bus.tx_done = 1'b1;
        end else if (bus.tx_start && !prev_start) begin
          cap = bus.tx_data;
          if (line_q.size() == 0) first_start_cyc = cyc;
          line_q.push_back(bus.tx_data);
          bus.tx_state = 1'b1;
          ucnt = $urandom_range(12, 30);
        end else if (spurious_en && !bus.tx_start && $urandom_range(0, 7) == 0) begin
          bus.tx_done = 1'b1;
        end
        if (bus.tx_start) start_len++;
        else if (start_len != 0) begin
          check("tx_start_width", start_len, 2);
          start_len = 0;
        end
        prev_start = bus.tx_start;
      end
    end
  end

  task automatic run_frame(input int len, input string tag, input bit repulse,
                           input bit use_const, input logic [15:0] const_crc);
    logic [15:0] exp_crc;
    logic [7:0]  exp_q [$];
    int          s, i;
    bit          did;
    exp_crc = use_const ? const_crc : crc_model(len);
    for (int k = 0; k < len; k++) exp_q.push_back(mem[k]);
    exp_q.push_back(exp_crc[7:0]);
    exp_q.push_back(exp_crc[15:8]);
    line_q.delete();
    first_start_cyc = -1;
    @(negedge clk);
    bus.frame_start = 1'b1;
    bus.frame_len   = len[ADDR_W-1:0];
    s = cyc;
    @(negedge clk);
    bus.frame_start = 1'b0;
    bus.frame_len   = 8'($urandom);
    check({tag, "_busy_rise"}, bus.busy, 1);
    i = 0; did = 0;
    while (!bus.frame_done && i < len * 64 + GAP_CYC + 200) begin
      if (repulse && !did && line_q.size() == 2) begin
        bus.frame_start = 1'b1;
        bus.frame_len   = 8'($urandom_range(1, 255));
        did = 1;
      end else begin
        bus.frame_start = 1'b0;
      end
      @(negedge clk);
      i++;
    end
    bus.frame_start = 1'b0;
    check({tag, "_done_seen"}, bus.frame_done, 1);
    check({tag, "_nbytes"}, line_q.size(), len + 2);
    foreach (exp_q[k])
      if (k < line_q.size()) check($sformatf("%s_byte%0d", tag, k), line_q[k], exp_q[k]);
    check({tag, "_crc_out"}, bus.crc_out, exp_crc);
    check({tag, "_gap"}, cyc - last_done_cyc, GAP_CYC);
    check({tag, "_latency"}, first_start_cyc - s, 4);
    check({tag, "_busy_in_done"}, bus.busy, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.frame_done, 0);
  endtask

  initial begin : watchdog
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: cycle limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] vec6 [6];
    int n_start, n_busy, n_rd, i;
    bus.frame_start = 1'b0;
    bus.frame_len   = '0;
    spurious_en     = 1'b0;

    // Reset state, then 100 quiet cycles after release.
    repeat (3) @(negedge clk);
    outputs_zero("reset");
    rst_n_in = 1'b1;
    n_start = 0; n_busy = 0;
    repeat (100) begin
      @(negedge clk);
      n_start += int'(bus.tx_start);
      n_busy  += int'(bus.busy);
    end
    check("post_reset_tx_start", n_start, 0);
    check("post_reset_busy", n_busy, 0);
    spurious_en = 1'b1;

    // Reference Modbus request.
    vec6 = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
    foreach (vec6[k]) mem[k] = vec6[k];
    run_frame(6, "modbus", 0, 1, 16'h0A84);

    // Zero-length request is ignored.
    @(negedge clk);
    bus.frame_start = 1'b1;
    bus.frame_len   = '0;
    @(negedge clk);
    bus.frame_start = 1'b0;
    n_start = 0; n_busy = 0; n_rd = 0;
    repeat (20) begin
      n_start += int'(bus.tx_start);
      n_busy  += int'(bus.busy);
      n_rd    += int'(bus.buf_rd_en);
      @(negedge clk);
    end
    check("len0_tx_start", n_start, 0);
    check("len0_busy", n_busy, 0);
    check("len0_rd_en", n_rd, 0);

    // Random payloads; one frame gets a second frame_start mid-flight.
    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(1, 24);
      for (int k = 0; k < len; k++) mem[k] = 8'($urandom);
      run_frame(len, $sformatf("rnd%0d", r), r == 2, 0, 16'h0);
    end

    // Length boundaries.
    mem[0] = 8'($urandom);
    run_frame(1, "len1", 0, 0, 16'h0);
    for (int k = 0; k < 255; k++) mem[k] = 8'($urandom);
    run_frame(255, "len255", 1, 0, 16'h0);

    // Reset while byte 3 is being started: outputs clear in the same cycle.
    for (int k = 0; k < 10; k++) mem[k] = 8'($urandom);
    line_q.delete();
    @(negedge clk);
    bus.frame_start = 1'b1;
    bus.frame_len   = 8'd10;
    @(negedge clk);
    bus.frame_start = 1'b0;
    i = 0;
    while (line_q.size() < 3 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check("rst_mid_reached_byte3", line_q.size() >= 3, 1);
    @(posedge clk);
    #2;
    rst_n_in = 1'b0;
    #1;
    outputs_zero("rst_mid");
    repeat (3) @(negedge clk);
    rst_n_in = 1'b1;
    repeat (5) @(negedge clk);

    // Fresh frame after reset: CRC must restart from FFFF.
    for (int k = 0; k < 9; k++) mem[k] = 8'h31 + 8'(k);
    run_frame(9, "ascii", 0, 1, 16'h4B37);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
